video_line_prefetch_ctrl: RTL

Schedules per-line frame-buffer read requests so that a line-slot ring buffer stays ahead of the video timing generator's scan-out. It sits between the timing generator (consumes `video_vsync`, `video_line_start`) and the memory read engine (drives a req/ack/done handshake). It also tracks buffer credits, selects the read slot for display, and flags underflow.

---
 rtl/video_line_prefetch_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/video_line_prefetch_ctrl.sv
// video_line_prefetch_ctrl: schedules frame-buffer line reads ahead of scan-out
// using a credit-tracked ring of line slots, and flags display underflow.
module video_line_prefetch_ctrl #(
    parameter int ADDR_W      = 28,
    parameter int LINES_AHEAD = 2,
    parameter int V_VISIBLE   = 1080,
    parameter int H_VISIBLE   = 1920,
    parameter int LINE_STRIDE = 4096
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic              video_vsync,
    input  logic              video_line_start,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [13:0]       rd_len,
    output logic [2:0]        rd_slot,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic [2:0]        disp_slot,
    output logic              frame_active,
    output logic              underflow
);
    localparam int FL_W = $clog2(V_VISIBLE + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;
    state_t state;
    logic vs_q, restart_pend;
    logic [FL_W-1:0] fetch_line;
    logic [3:0] credits, filled;
    logic [2:0] wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] addr_acc;
    logic frame_start, consume, take, pend_eff, ack_ok, done_ok, restart_now;
    assign frame_start = video_vsync & ~vs_q;
    assign consume     = video_line_start & (frame_active | filled != 0);
    assign take        = consume & (filled != 0);
    // a frame start landing mid-transaction turns that transaction into a stale one
    assign pend_eff    = restart_pend | (frame_start & enable);
    assign ack_ok      = state == ISSUE & rd_ack & ~pend_eff;
    assign done_ok     = state == BUSY & rd_done & ~pend_eff;
    assign restart_now = enable & (frame_start & (state == IDLE | state == HOLD) | state == BUSY & rd_done & pend_eff);
    assign rd_len      = 14'(H_VISIBLE);
    assign rd_addr     = addr_acc;
    assign rd_slot     = wr_ptr;
    assign disp_slot   = rd_ptr;
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state        <= IDLE;
            vs_q         <= 1'b0;
            restart_pend <= 1'b0;
            rd_req       <= 1'b0;
            fetch_line   <= '0;
            credits      <= '0;
            filled       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            addr_acc     <= '0;
            frame_active <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            vs_q <= video_vsync;
            if (restart_now) begin
                state        <= ISSUE;
                rd_req       <= 1'b1;
                restart_pend <= 1'b0;
                fetch_line   <= '0;
                credits      <= 4'(LINES_AHEAD);
                filled       <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                addr_acc     <= frame_base;
                underflow    <= 1'b0;
                frame_active <= 1'b1;
            end else begin
                if (take)
                    rd_ptr <= rd_ptr == 3'(LINES_AHEAD - 1) ? 3'd0 : rd_ptr + 3'd1;
                else if (consume)
                    underflow <= 1'b1;
                filled  <= filled + 4'(done_ok) - 4'(take);
                credits <= credits - 4'(ack_ok) + 4'(take);
                if (ack_ok) begin
                    addr_acc   <= addr_acc + ADDR_W'(LINE_STRIDE);
                    fetch_line <= fetch_line + FL_W'(1);
                end
                if (done_ok)
                    wr_ptr <= wr_ptr == 3'(LINES_AHEAD - 1) ? 3'd0 : wr_ptr + 3'd1;
                if (enable & frame_start & (state == ISSUE | state == BUSY))
                    restart_pend <= 1'b1;
                case (state)
                    ISSUE: if (rd_ack) begin
                        state  <= BUSY;
                        rd_req <= 1'b0;
                    end
                    BUSY: if (rd_done) begin
                        restart_pend <= 1'b0;
                        if (pend_eff) state <= IDLE;
                        else if (fetch_line == FL_W'(V_VISIBLE)) begin
                            frame_active <= 1'b0;
                            state        <= IDLE;
                        end else if (!enable) state <= IDLE;
                        else if (credits != 0) begin
                            state  <= ISSUE;
                            rd_req <= 1'b1;
                        end else state <= HOLD;
                    end
                    HOLD: if (!enable) state <= IDLE;
                    else if (credits != 0 || take) begin
                        state  <= ISSUE;
                        rd_req <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
